parking_lot_controller: RTL and testbench

- Sequential occupancy and gate controller for the 8-space parking lot.
- Sits directly downstream of the exit decoder and consumes its 8-bit one-hot exit location.
- Allocates the lowest free space to arriving cars, frees spaces on exit, drives the entry gate timer, and reports full/empty/free count.

---
 rtl/parking_lot_controller_pkg.sv | 16 +
 rtl/parking_lot_controller_if.sv | 44 ++++
 rtl/parking_lot_controller_free_slot_finder.sv | 22 ++
 rtl/parking_lot_controller.sv | 142 ++++++++++++++
 tb/tb_parking_lot_controller.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/parking_lot_controller_pkg.sv
// rtl/parking_lot_controller_pkg.sv - shared constants and FSM encoding for the parking lot controller
package parking_pkg;

    localparam int NUM_SPACES          = 8;
    localparam int IDX_W               = 3;
    localparam int CNT_W               = 4;
    localparam int TIMER_W             = 4;
    localparam int GATE_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GATE  = 2'd2
    } state_e;

endpackage

// File: rtl/parking_lot_controller_if.sv
// rtl/parking_lot_controller_if.sv - entry/exit request and status bundle; PARKING_STATS_EN adds counters
interface parking_lot_controller_if;
    import parking_pkg::*;

    logic                  entry_req;
    logic                  exit_req;
    logic [NUM_SPACES-1:0] exit_location;
    logic [NUM_SPACES-1:0] occupancy;
    logic [IDX_W-1:0]      entry_park_number;
    logic                  entry_ack;
    logic                  entry_reject;
    logic                  exit_error;
    logic                  gate_open;
    logic [CNT_W-1:0]      free_count;
    logic                  full;
    logic                  empty;
`ifdef PARKING_STATS_EN
    logic [15:0]           entries_total;
    logic [7:0]            rejects_total;

    modport master (
        output entry_req, exit_req, exit_location,
        input  occupancy, entry_park_number, entry_ack, entry_reject, exit_error,
               gate_open, free_count, full, empty, entries_total, rejects_total
    );
    modport slave (
        input  entry_req, exit_req, exit_location,
        output occupancy, entry_park_number, entry_ack, entry_reject, exit_error,
               gate_open, free_count, full, empty, entries_total, rejects_total
    );
`else
    modport master (
        output entry_req, exit_req, exit_location,
        input  occupancy, entry_park_number, entry_ack, entry_reject, exit_error,
               gate_open, free_count, full, empty
    );
    modport slave (
        input  entry_req, exit_req, exit_location,
        output occupancy, entry_park_number, entry_ack, entry_reject, exit_error,
               gate_open, free_count, full, empty
    );
`endif

endinterface

// File: rtl/parking_lot_controller_free_slot_finder.sv
// rtl/parking_lot_controller_free_slot_finder.sv - lowest-index free space priority encoder
module free_slot_finder
    import parking_pkg::*;
(
    input  logic [NUM_SPACES-1:0] occupancy_i,
    output logic [IDX_W-1:0]      free_idx_o,
    output logic                  any_free_o
);

    always_comb begin
        free_idx_o = '0;
        any_free_o = 1'b0;
        // Scan downward so the last hit, the lowest free index, wins.
        for (int i = NUM_SPACES - 1; i >= 0; i--) begin
            if (!occupancy_i[i]) begin
                free_idx_o = IDX_W'(i);
                any_free_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/parking_lot_controller.sv
// rtl/parking_lot_controller.sv - occupancy tracking and entry gate FSM; PARKING_STATS_EN adds entry/reject counters
module parking_lot_controller
    import parking_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEFAULT
)
(
    input  logic                    clk,
    input  logic                    rst,
    parking_lot_controller_if.slave bus
);

    state_e                state_q, state_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_SPACES-1:0] occupancy_q, occupancy_d;
    logic [IDX_W-1:0]      park_num_q, park_num_d;
    logic                  ack_q, ack_d;
    logic                  reject_q, reject_d;
    logic                  exit_err_q, exit_err_d;
    logic                  gate_q, gate_d;

    logic [IDX_W-1:0]      free_idx;
    logic                  any_free;
    logic                  grant;
    logic                  exit_legal;
    logic [NUM_SPACES-1:0] grant_mask;
    logic [NUM_SPACES-1:0] clear_mask;

    free_slot_finder u_finder (
        .occupancy_i (occupancy_q),
        .free_idx_o  (free_idx),
        .any_free_o  (any_free)
    );

    assign exit_legal = bus.exit_req && $onehot(bus.exit_location)
                        && ((occupancy_q & bus.exit_location) != '0);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        gate_d     = gate_q;
        ack_d      = 1'b0;
        reject_d   = 1'b0;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.entry_req) begin
                    if (any_free) begin
                        grant   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = GRANT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                timer_d = TIMER_W'(GATE_CYCLES);
                gate_d  = 1'b1;
                state_d = GATE;
            end
            GATE: begin
                if (timer_q <= TIMER_W'(1)) begin
                    timer_d = '0;
                    gate_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
                timer_d = '0;
            end
        endcase
    end

    // Allocation is computed from pre-exit occupancy, so a space freed this cycle is never granted this cycle.
    always_comb begin
        grant_mask  = grant ? (NUM_SPACES'(1) << free_idx) : '0;
        clear_mask  = exit_legal ? bus.exit_location : '0;
        occupancy_d = (occupancy_q | grant_mask) & ~clear_mask;
        park_num_d  = grant ? free_idx : park_num_q;
        exit_err_d  = bus.exit_req && !exit_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            occupancy_q <= '0;
            park_num_q  <= '0;
            ack_q       <= 1'b0;
            reject_q    <= 1'b0;
            exit_err_q  <= 1'b0;
            gate_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occupancy_q <= occupancy_d;
            park_num_q  <= park_num_d;
            ack_q       <= ack_d;
            reject_q    <= reject_d;
            exit_err_q  <= exit_err_d;
            gate_q      <= gate_d;
        end
    end

    assign bus.occupancy         = occupancy_q;
    assign bus.entry_park_number = park_num_q;
    assign bus.entry_ack         = ack_q;
    assign bus.entry_reject      = reject_q;
    assign bus.exit_error        = exit_err_q;
    assign bus.gate_open         = gate_q;
    assign bus.free_count        = CNT_W'(NUM_SPACES - $countones(occupancy_q));
    assign bus.full              = (occupancy_q == '1);
    assign bus.empty             = (occupancy_q == '0);

`ifdef PARKING_STATS_EN
    logic [15:0] entries_q;
    logic [7:0]  rejects_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '0;
            rejects_q <= '0;
        end else begin
            if (ack_d && (entries_q != 16'hFFFF)) begin
                entries_q <= entries_q + 16'd1;
            end
            if (reject_d && (rejects_q != 8'hFF)) begin
                rejects_q <= rejects_q + 8'd1;
            end
        end
    end

    assign bus.entries_total = entries_q;
    assign bus.rejects_total = rejects_q;
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// tb/tb_parking_lot_controller.sv - directed self-checking bench for parking_lot_controller
module tb_parking_lot_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    parking_lot_controller_if bus ();

    parking_lot_controller #(.GATE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // One full entry transaction: request, check grant, then run out the gate back to IDLE.
    task automatic do_entry(input logic [2:0] exp_idx);
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("entry_ack", 32'(bus.entry_ack), 32'd1);
        check("park_number", 32'(bus.entry_park_number), 32'(exp_idx));
        for (int i = 0; i < 5; i++) step();
    endtask

    initial begin
        bus.entry_req     = 1'b0;
        bus.exit_req      = 1'b0;
        bus.exit_location = 8'h00;
        step();
        step();

        check("rst_occupancy", 32'(bus.occupancy), 32'h00);
        check("rst_free_count", 32'(bus.free_count), 32'd8);
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_gate", 32'(bus.gate_open), 32'd0);
        check("rst_park_number", 32'(bus.entry_park_number), 32'd0);
        rst = 1'b0;
        step();

        // Single entry and gate window
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("t1_ack", 32'(bus.entry_ack), 32'd1);
        check("t1_park", 32'(bus.entry_park_number), 32'd0);
        check("t1_occ", 32'(bus.occupancy), 32'h01);
        check("t1_free", 32'(bus.free_count), 32'd7);
        check("t1_gate_pre", 32'(bus.gate_open), 32'd0);
        step();
        check("t1_ack_pulse", 32'(bus.entry_ack), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t1_gate_high", 32'(bus.gate_open), 32'd1);
            step();
        end
        check("t1_gate_low", 32'(bus.gate_open), 32'd0);

        // Fill from empty, then reject while full
        do_reset();
        for (int i = 0; i < 8; i++) do_entry(3'(i));
        check("fill_occ", 32'(bus.occupancy), 32'hFF);
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_free", 32'(bus.free_count), 32'd0);
        bus.entry_req = 1'b1;
        step();
        check("rej_pulse", 32'(bus.entry_reject), 32'd1);
        check("rej_no_ack", 32'(bus.entry_ack), 32'd0);
        check("rej_occ", 32'(bus.occupancy), 32'hFF);
        step();
        check("rej_repeat", 32'(bus.entry_reject), 32'd1);
        bus.entry_req = 1'b0;
        step();
        check("rej_clear", 32'(bus.entry_reject), 32'd0);

        // Legal exit from full, then the freed space is re-granted
        bus.exit_req      = 1'b1;
        bus.exit_location = 8'h04;
        step();
        bus.exit_req      = 1'b0;
        check("exit_occ", 32'(bus.occupancy), 32'hFB);
        check("exit_no_err", 32'(bus.exit_error), 32'd0);
        do_entry(3'd2);
        check("regrant_occ", 32'(bus.occupancy), 32'hFF);

        // Illegal exits leave occupancy alone
        do_reset();
        do_entry(3'd0);
        bus.exit_req      = 1'b1;
        bus.exit_location = 8'h02;
        step();
        check("ill_free_err", 32'(bus.exit_error), 32'd1);
        check("ill_free_occ", 32'(bus.occupancy), 32'h01);
        bus.exit_location = 8'h03;
        step();
        check("ill_two_err", 32'(bus.exit_error), 32'd1);
        check("ill_two_occ", 32'(bus.occupancy), 32'h01);
        bus.exit_location = 8'h00;
        step();
        check("ill_zero_err", 32'(bus.exit_error), 32'd1);
        bus.exit_req = 1'b0;
        step();
        check("ill_err_clear", 32'(bus.exit_error), 32'd0);
        check("ill_final_occ", 32'(bus.occupancy), 32'h01);

        // Simultaneous entry and exit
        do_reset();
        for (int i = 0; i < 8; i++) do_entry(3'(i));
        bus.exit_req      = 1'b1;
        bus.exit_location = 8'h01;
        step();
        bus.exit_req      = 1'b0;
        check("sim_setup_occ", 32'(bus.occupancy), 32'hFE);
        bus.entry_req     = 1'b1;
        bus.exit_req      = 1'b1;
        bus.exit_location = 8'h02;
        step();
        bus.entry_req     = 1'b0;
        bus.exit_req      = 1'b0;
        check("sim_ack", 32'(bus.entry_ack), 32'd1);
        check("sim_park", 32'(bus.entry_park_number), 32'd0);
        check("sim_occ", 32'(bus.occupancy), 32'hFD);
        for (int i = 0; i < 5; i++) step();
        do_entry(3'd1);
        check("sim_full_occ", 32'(bus.occupancy), 32'hFF);
        bus.entry_req     = 1'b1;
        bus.exit_req      = 1'b1;
        bus.exit_location = 8'h02;
        step();
        bus.entry_req     = 1'b0;
        bus.exit_req      = 1'b0;
        check("simf_reject", 32'(bus.entry_reject), 32'd1);
        check("simf_no_ack", 32'(bus.entry_ack), 32'd0);
        check("simf_occ", 32'(bus.occupancy), 32'hFD);

        // Asynchronous reset in the middle of the gate window
        do_reset();
        do_entry(3'd0);
        do_entry(3'd1);
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        step();
        step();
        check("ar_gate_before", 32'(bus.gate_open), 32'd1);
        check("ar_occ_before", 32'(bus.occupancy), 32'h07);
        #2;
        rst = 1'b1;
        #1;
        check("ar_gate", 32'(bus.gate_open), 32'd0);
        check("ar_occ", 32'(bus.occupancy), 32'h00);
        check("ar_free", 32'(bus.free_count), 32'd8);
        check("ar_empty", 32'(bus.empty), 32'd1);
        step();
        rst = 1'b0;
        bus.entry_req = 1'b1;
        step();
        bus.entry_req = 1'b0;
        check("ar_idle_ack", 32'(bus.entry_ack), 32'd1);
        check("ar_idle_park", 32'(bus.entry_park_number), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
